entry_ob: RTL

Output buffer between `fetch` and the serializer back-end. Captures each `TABLE_ENTRY` that `fetch` presents with a one-cycle `ob_valid` pulse, stores it in a first-word-fall-through FIFO, and hands entries downstream with a valid/ready handshake. It drives `ob_full` back to `fetch` with enough margin that no entry is lost while `fetch` finishes an in-flight DRAM read.

---
 rtl/entry_ob.sv | 83 ++++++++
 1 files changed

// File: rtl/entry_ob.sv
// entry_ob: first-word-fall-through output buffer between fetch and
// the serializer, with early back-pressure and a sticky overflow flag.
module entry_ob #(
    parameter int ENTRY_W   = 128,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [ENTRY_W-1:0]         in_entry,
    output logic                       full,
    output logic                       out_valid,
    output logic [ENTRY_W-1:0]         out_entry,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL  = CW'(DEPTH - AF_MARGIN);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               pop;
    logic               push_ok;

    assign out_valid = (count_q != '0);
    assign out_entry = mem_q[rd_ptr_q];
    assign full      = (count_q >= AF_LVL);
    assign count     = count_q;
    assign overflow  = overflow_q;

    assign pop     = out_valid & out_ready;
    assign push_ok = in_valid & ((count_q < DEPTH_C) | pop);

    // Next-state for pointers, occupancy and the sticky drop flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push_ok) count_d = count_q - 1'b1;
            if (in_valid && !push_ok) overflow_d = 1'b1;
        end
    end

    // Control state register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage is data-only and never reset.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= in_entry;
    end

endmodule
